cosx_ctrl: RTL

Control FSM for the cosine-series datapath. It accepts a start request, then sequences the datapath's register loads, multiplexer selects, counter and add/subtract controls through the Taylor-series loop. It terminates on the last table term or on early exit, then pulses `done`. It sits directly upstream of the datapath: every control output wires one-to-one to the datapath control input of the same name, and the datapath's `Co` and `addGTy` come back as status inputs.

---
 rtl/cosx_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cosx_ctrl.sv
// cosx_ctrl: control FSM for the cosine Taylor-series datapath.
// Sequences register loads, multiplier operand selects, term counter and
// add/subtract control; ends on the last table term (Co) or on early exit
// (addGTy = 0) and then pulses done for one cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               run request, sampled only in IDLE
//   Co, addGTy          datapath status: counter at last term, (res +/- temp) >= Y
//   ldx, ldy, ldx2      load X, Y, x^2 registers
//   Init_temp, Init_res preset temp / res to 1.0
//   ld_temp, ld_res     load temp from multiplier / res from adder
//   aos                 1 = add, 0 = subtract
//   seltemp, selxp      multiplier operand A = temp / x
//   selx, selx2, selTbl multiplier operand B = x / x^2 / table[count]
//   Init_cnt, Inc_cnt   clear / increment term counter
//   busy, done, early   status: running, completion pulse, last run exited early
module cosx_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic Co,
  input  logic addGTy,
  output logic ldx,
  output logic ldy,
  output logic ldx2,
  output logic Init_temp,
  output logic Init_res,
  output logic ld_temp,
  output logic ld_res,
  output logic aos,
  output logic seltemp,
  output logic selxp,
  output logic selx,
  output logic selx2,
  output logic selTbl,
  output logic Init_cnt,
  output logic Inc_cnt,
  output logic busy,
  output logic done,
  output logic early
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSqr,
    StMulX2,
    StMulTbl,
    StAcc,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic   sgn_q, sgn_d;
  logic   early_q, early_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sgn_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      early_q <= early_d;
    end
  end

  assign early = early_q;

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    early_d   = early_q;
    ldx       = 1'b0;
    ldy       = 1'b0;
    ldx2      = 1'b0;
    Init_temp = 1'b0;
    Init_res  = 1'b0;
    ld_temp   = 1'b0;
    ld_res    = 1'b0;
    aos       = 1'b0;
    seltemp   = 1'b0;
    selxp     = 1'b0;
    selx      = 1'b0;
    selx2     = 1'b0;
    selTbl    = 1'b0;
    Init_cnt  = 1'b0;
    Inc_cnt   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StLoad;
      end
      StLoad: begin
        ldx       = 1'b1;
        ldy       = 1'b1;
        Init_temp = 1'b1;
        Init_res  = 1'b1;
        Init_cnt  = 1'b1;
        sgn_d     = 1'b0;
        early_d   = 1'b0;
        state_d   = StSqr;
      end
      StSqr: begin
        selxp   = 1'b1;
        selx    = 1'b1;
        ldx2    = 1'b1;
        state_d = StMulX2;
      end
      StMulX2: begin
        seltemp = 1'b1;
        selx2   = 1'b1;
        ld_temp = 1'b1;
        state_d = StMulTbl;
      end
      StMulTbl: begin
        seltemp = 1'b1;
        selTbl  = 1'b1;
        ld_temp = 1'b1;
        state_d = StAcc;
      end
      StAcc: begin
        aos = sgn_q;
        if (!addGTy) begin
          // Next term would overshoot Y: keep res and stop.
          early_d = 1'b1;
          state_d = StDone;
        end else begin
          ld_res = 1'b1;
          if (Co) begin
            state_d = StDone;
          end else begin
            // Counter only advances when another term follows, so it never wraps.
            Inc_cnt = 1'b1;
            sgn_d   = ~sgn_q;
            state_d = StMulX2;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule
